// File: rtl/ftq_pd_mem_arbiter_pkg.sv
// Shared types and sizing for the FTQ predecode memory read-port arbiter.
package ftq_pd_arb_pkg;

  localparam int FTQ_PD_NUM_REQ   = 3;
  localparam int FTQ_PD_ADDR_W    = 6;
  localparam int FTQ_PD_NUM_RPORT = 2;

  typedef logic [FTQ_PD_ADDR_W-1:0] ftq_idx_t;

  typedef struct packed {
    logic grant;
    logic port;
  } pd_grant_t;

endpackage

// File: rtl/ftq_pd_mem_arbiter_if.sv
// Requester, write-forward and memory read-port bundle of the FTQ predecode arbiter.
interface ftq_pd_mem_arbiter_if;
  import ftq_pd_arb_pkg::*;

  logic [FTQ_PD_NUM_REQ-1:0]            req_valid;
  ftq_idx_t [FTQ_PD_NUM_REQ-1:0]        req_addr;
  logic [FTQ_PD_NUM_REQ-1:0]            req_ready;
  logic                                 flush;
  logic                                 wr_valid;
  ftq_idx_t                             wr_addr;
  logic                                 mem_ren_0;
  logic                                 mem_ren_1;
  ftq_idx_t                             mem_raddr_0;
  ftq_idx_t                             mem_raddr_1;
  logic                                 mem_wen_0;
  ftq_idx_t                             mem_waddr_0;
  logic [FTQ_PD_NUM_REQ-1:0]            resp_valid;
  logic [FTQ_PD_NUM_REQ-1:0]            resp_port;

  modport master (
    output req_valid, req_addr, flush, wr_valid, wr_addr,
    input  req_ready, mem_ren_0, mem_ren_1, mem_raddr_0, mem_raddr_1,
           mem_wen_0, mem_waddr_0, resp_valid, resp_port
  );

  modport slave (
    input  req_valid, req_addr, flush, wr_valid, wr_addr,
    output req_ready, mem_ren_0, mem_ren_1, mem_raddr_0, mem_raddr_1,
           mem_wen_0, mem_waddr_0, resp_valid, resp_port
  );

endinterface

// File: rtl/ftq_pd_mem_arbiter_rr_pick.sv
// Two-way round-robin picker for requesters 1/2; with a single free slot the
// favored one wins and the pointer moves to the loser.
module ftq_pd_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  input  logic       single_slot_i,
  output logic [1:0] grant_o,
  output logic       ptr_next_o
);

  // grant selection and pointer update
  always_comb begin
    grant_o    = 2'b00;
    ptr_next_o = ptr_i;
    if (single_slot_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11: begin
          grant_o    = ptr_i ? 2'b10 : 2'b01;
          ptr_next_o = ~ptr_i;
        end
        default: grant_o = 2'b00;
      endcase
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/ftq_pd_mem_arbiter.sv
// FTQ predecode memory read arbiter: req0 fixed priority, req1/req2 round-robin.
// Optional FTQ_PD_ARB_WR_BLOCK_EN suppresses reads colliding with a same-cycle write.
module ftq_pd_mem_arbiter
  import ftq_pd_arb_pkg::*;
#(
  parameter int NUM_REQ = FTQ_PD_NUM_REQ,
  parameter int ADDR_W  = FTQ_PD_ADDR_W
) (
  input logic                 clock,
  input logic                 reset,
  ftq_pd_mem_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0]    elig_s;
  logic [1:0]            rr_grant_s;
  logic                  rr_ptr_d;
  logic                  rr_ptr_q;
  pd_grant_t [NUM_REQ-1:0] grant_d;
  logic                  ren0_s;
  logic                  ren1_s;
  logic [ADDR_W-1:0]     raddr0_s;
  logic [ADDR_W-1:0]     raddr1_s;
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [NUM_REQ-1:0]    resp_port_q;

  // request eligibility (optionally masked by write collision)
  always_comb begin
    elig_s = bus.req_valid;
`ifdef FTQ_PD_ARB_WR_BLOCK_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.wr_valid && (bus.req_addr[i] == bus.wr_addr)) begin
        elig_s[i] = 1'b0;
      end else begin
        elig_s[i] = bus.req_valid[i];
      end
    end
`endif
  end

  ftq_pd_rr_pick u_rr_pick (
    .valid_i       (elig_s[2:1]),
    .ptr_i         (rr_ptr_q),
    .single_slot_i (elig_s[0]),
    .grant_o       (rr_grant_s),
    .ptr_next_o    (rr_ptr_d)
  );

  // winners and read-port steering; req2 lands on port 1 whenever a lower index also won
  always_comb begin
    grant_d        = '0;
    ren0_s         = 1'b0;
    ren1_s         = 1'b0;
    raddr0_s       = '0;
    raddr1_s       = '0;
    grant_d[0]     = '{grant: elig_s[0],    port: 1'b0};
    grant_d[1]     = '{grant: rr_grant_s[0], port: elig_s[0]};
    grant_d[2]     = '{grant: rr_grant_s[1], port: elig_s[0] | rr_grant_s[0]};
    for (int i = 0; i < NUM_REQ; i++) begin
      case ({grant_d[i].grant, grant_d[i].port})
        2'b10: begin
          ren0_s   = 1'b1;
          raddr0_s = bus.req_addr[i];
        end
        2'b11: begin
          ren1_s   = 1'b1;
          raddr1_s = bus.req_addr[i];
        end
        default: ;
      endcase
    end
  end

  // pointer and response state captured at the grant edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_port_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        resp_valid_q[i] <= grant_d[i].grant;
        if (grant_d[i].grant) begin
          resp_port_q[i] <= grant_d[i].port;
        end else begin
          resp_port_q[i] <= resp_port_q[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = grant_d[i].grant;
    end
  end

  assign bus.mem_ren_0   = ren0_s;
  assign bus.mem_ren_1   = ren1_s;
  assign bus.mem_raddr_0 = raddr0_s;
  assign bus.mem_raddr_1 = raddr1_s;
  assign bus.mem_wen_0   = bus.wr_valid;
  assign bus.mem_waddr_0 = bus.wr_addr;
  assign bus.resp_valid  = resp_valid_q & ~{NUM_REQ{bus.flush}};
  assign bus.resp_port   = resp_port_q & ~{NUM_REQ{bus.flush}};

endmodule

// File: tb/tb_ftq_pd_mem_arbiter.sv
// Directed bench for ftq_pd_mem_arbiter: per-cycle grant checks plus a response scoreboard.
module tb_ftq_pd_mem_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [5:0] sb_q[$];

  ftq_pd_mem_arbiter_if bus ();

  ftq_pd_mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock cycle: drive inputs, check outputs, queue the expected response
  task automatic cyc(input logic [2:0] v, input logic [5:0] a0, input logic [5:0] a1,
                     input logic [5:0] a2, input logic fl, input logic wv, input logic [5:0] wa,
                     input logic [2:0] e_rdy, input logic e_ren0, input logic [5:0] e_ra0,
                     input logic e_ren1, input logic [5:0] e_ra1, input logic [2:0] e_port);
    logic [5:0] expr;
    @(negedge clock);
    bus.req_valid   = v;
    bus.req_addr[0] = a0;
    bus.req_addr[1] = a1;
    bus.req_addr[2] = a2;
    bus.flush       = fl;
    bus.wr_valid    = wv;
    bus.wr_addr     = wa;
    #1;
    expr = 6'd0;
    if (sb_q.size() > 0) expr = sb_q.pop_front();
    if (fl) expr = 6'd0;
    chk("resp_valid", {5'd0, bus.resp_valid}, {5'd0, expr[5:3]});
    chk("resp_port", {5'd0, bus.resp_port & expr[5:3]}, {5'd0, expr[2:0]});
    chk("req_ready", {5'd0, bus.req_ready}, {5'd0, e_rdy});
    chk("mem_ren_0", {7'd0, bus.mem_ren_0}, {7'd0, e_ren0});
    chk("mem_raddr_0", {2'd0, bus.mem_raddr_0}, {2'd0, e_ra0});
    chk("mem_ren_1", {7'd0, bus.mem_ren_1}, {7'd0, e_ren1});
    chk("mem_raddr_1", {2'd0, bus.mem_raddr_1}, {2'd0, e_ra1});
    chk("mem_wen_0", {7'd0, bus.mem_wen_0}, {7'd0, wv});
    chk("mem_waddr_0", {2'd0, bus.mem_waddr_0}, {2'd0, wa});
    sb_q.push_back({e_rdy, e_port});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req_valid = 3'd0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = 6'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_resp_valid", {5'd0, bus.resp_valid}, 8'd0);
    chk("rst_resp_port", {5'd0, bus.resp_port}, 8'd0);
    reset = 1'b0;

    //  v       a0     a1      a2      fl    wv    wa     rdy     ren0  ra0     ren1  ra1     port
    cyc(3'b010, 6'd0,  6'd5,  6'd0,  1'b0, 1'b0, 6'd0,  3'b010, 1'b1, 6'd5,  1'b0, 6'd0,  3'b000);
    cyc(3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  3'b000, 1'b0, 6'd0,  1'b0, 6'd0,  3'b000);
    cyc(3'b111, 6'd3,  6'd7,  6'd9,  1'b0, 1'b0, 6'd0,  3'b011, 1'b1, 6'd3,  1'b1, 6'd7,  3'b010);
    cyc(3'b111, 6'd3,  6'd7,  6'd9,  1'b0, 1'b0, 6'd0,  3'b101, 1'b1, 6'd3,  1'b1, 6'd9,  3'b100);
    cyc(3'b111, 6'd3,  6'd7,  6'd9,  1'b0, 1'b0, 6'd0,  3'b011, 1'b1, 6'd3,  1'b1, 6'd7,  3'b010);
    cyc(3'b110, 6'd0,  6'd10, 6'd11, 1'b0, 1'b0, 6'd0,  3'b110, 1'b1, 6'd10, 1'b1, 6'd11, 3'b100);
    // pointer must still favor req2 after the both-granted cycle
    cyc(3'b111, 6'd3,  6'd7,  6'd9,  1'b0, 1'b0, 6'd0,  3'b101, 1'b1, 6'd3,  1'b1, 6'd9,  3'b100);
    cyc(3'b100, 6'd0,  6'd0,  6'd20, 1'b0, 1'b0, 6'd0,  3'b100, 1'b1, 6'd20, 1'b0, 6'd0,  3'b000);
    cyc(3'b001, 6'd1,  6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  3'b001, 1'b1, 6'd1,  1'b0, 6'd0,  3'b000);
    cyc(3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  3'b000, 1'b0, 6'd0,  1'b0, 6'd0,  3'b000);
`ifdef FTQ_PD_ARB_WR_BLOCK_EN
    cyc(3'b011, 6'd12, 6'd4,  6'd0,  1'b0, 1'b1, 6'd12, 3'b010, 1'b1, 6'd4,  1'b0, 6'd0,  3'b000);
`else
    cyc(3'b011, 6'd12, 6'd4,  6'd0,  1'b0, 1'b1, 6'd12, 3'b011, 1'b1, 6'd12, 1'b1, 6'd4,  3'b010);
`endif
    cyc(3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  3'b000, 1'b0, 6'd0,  1'b0, 6'd0,  3'b000);
    cyc(3'b111, 6'd3,  6'd7,  6'd9,  1'b0, 1'b0, 6'd0,  3'b011, 1'b1, 6'd3,  1'b1, 6'd7,  3'b010);

    // reset in the response cycle drops the pending response and the pointer
    @(negedge clock);
    bus.req_valid = 3'd0;
    reset = 1'b1;
    #1;
    chk("rst_mid_resp_valid", {5'd0, bus.resp_valid}, 8'd0);
    sb_q.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_rel_resp_valid", {5'd0, bus.resp_valid}, 8'd0);

    cyc(3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  3'b000, 1'b0, 6'd0,  1'b0, 6'd0,  3'b000);
    cyc(3'b111, 6'd3,  6'd7,  6'd9,  1'b0, 1'b0, 6'd0,  3'b011, 1'b1, 6'd3,  1'b1, 6'd7,  3'b010);
    cyc(3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  3'b000, 1'b0, 6'd0,  1'b0, 6'd0,  3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ftq_pd_mem_arbiter.md
# ftq_pd_mem_arbiter

Read-port arbiter and sequencer for the FTQ predecode memory (64-entry, 2 synchronous read ports, 1 write port). Three requesters (backend redirect, IFU writeback check, commit) share the two read ports. The block issues `ren`/`raddr` to the memory, then returns a one-cycle-delayed response strobe that tells each winner which memory read port carries its data. Optionally, it blocks reads that collide with a same-cycle write.

## Interface
Parameters:
- `NUM_REQ`, 3, number of read requesters (fixed priority index 0, round-robin 1..2)
- `ADDR_W`, 6, FTQ index width (64 entries)

Ports:
- `clock` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `req_valid` in NUM_REQ — read request per requester
- `req_addr` in NUM_REQ×ADDR_W — FTQ index per requester
- `req_ready` out NUM_REQ — grant this cycle (handshake fires on valid&ready)
- `flush` in 1 — kill responses issued from the previous cycle
- `wr_valid` in 1 — write request from predecode writeback
- `wr_addr` in ADDR_W — write index
- `mem_ren_0`, `mem_ren_1` out 1 — memory read enables
- `mem_raddr_0`, `mem_raddr_1` out ADDR_W — memory read addresses
- `mem_wen_0` out 1; `mem_waddr_0` out ADDR_W — forwarded write controls (combinational pass-through)
- `resp_valid` out NUM_REQ — read data valid for requester, one cycle after grant
- `resp_port` out NUM_REQ — memory read port (0/1) holding that requester's data

## Operation
- Requester 0 has fixed highest priority and always takes port 0 when it is valid and not blocked.
- Requesters 1 and 2 compete for the remaining port(s) round-robin. `rr_ptr` (1 bit) selects the favored one: 0 favors requester 1, 1 favors requester 2.
- Port assignment per cycle follows from the winners:
  - If req0 wins, it takes port 0 and the best of {1,2} takes port 1.
  - If req0 is absent, both 1 and 2 can win. The lower index takes port 0.
  - A single winner always uses port 0.
- `rr_ptr` flips only when both 1 and 2 were valid and exactly one was granted. It toggles so that the loser is favored next cycle.
- `req_ready[i]` is combinational and asserted only when requester i is granted. Non-granted valid requests are expected to hold.
- `mem_ren_k` is 1 only when port k is granted. `mem_raddr_k` equals the winner's address; it is 0 when the port is idle.
- Registered response state: `resp_valid_q[i]` and `resp_port_q[i]` are captured at the grant edge. The outputs are these registers gated by `~flush` (combinational).
- `flush` in the grant cycle does not affect grants.

## Timing
- Grant to `resp_valid`: exactly 1 cycle. Memory data is valid on the indicated port in that same cycle.
- Back-to-back grants to the same requester are allowed every cycle.
- Reset values:
  - `rr_ptr` = 0; all `resp_valid_q` = 0; all `resp_port_q` = 0.
  - Hence after reset `resp_valid` = 0 and `resp_port` = 0.
  - `req_ready`, `mem_ren_*` and `mem_raddr_*` follow combinationally from the inputs.
- Reset asserted mid-operation clears pending responses immediately. No response is emitted after reset deasserts for grants made before it.
- With all requesters idle: both `mem_ren` = 0, no state change.
- `wr_valid` passes straight through to the memory in the same cycle.

## Configuration
- `FTQ_PD_ARB_WR_BLOCK_EN` defined:
  - A request whose `req_addr` equals `wr_addr` while `wr_valid` = 1 is treated as not valid that cycle. It gets no grant and does not affect `rr_ptr`.
  - Its port slot goes to the next eligible requester.
- Not defined: no address comparison; colliding reads are granted and return pre-write data.

## Structure
- Package `ftq_pd_arb_pkg` holds:
  - constants `FTQ_PD_NUM_REQ` = 3, `FTQ_PD_ADDR_W` = 6, `FTQ_PD_NUM_RPORT` = 2;
  - typedef `ftq_idx_t` (ADDR_W-bit index);
  - typedef `pd_grant_t` (per-requester grant bit plus port bit).
- One sub-module, `ftq_pd_rr_pick`: a two-way round-robin picker. It takes `valid[1:0]` and `ptr`, and returns `grant[1:0]` (first and second choice) plus `ptr_next`.

## Test plan
- After reset, only req1 valid with addr 5 → `req_ready[1]` = 1, `mem_ren_0` = 1, `mem_raddr_0` = 5. Next cycle `resp_valid[1]` = 1, `resp_port[1]` = 0.
- req0 (addr 3), req1 (addr 7) and req2 (addr 9) all valid for 3 cycles:
  - req0 is granted on port 0 every cycle.
  - Port 1 alternates req1, req2, req1, with `rr_ptr` toggling each cycle.
- req1 (addr 10) and req2 (addr 11) valid, req0 idle → both granted: req1 on port 0, req2 on port 1. `rr_ptr` unchanged. Responses the next cycle carry `resp_port` 0 and 1.
- Grant req2 at cycle N, assert `flush` at N+1 → `resp_valid[2]` = 0 at N+1.
- With `FTQ_PD_ARB_WR_BLOCK_EN`: `wr_valid` = 1, `wr_addr` = 12, req0 addr 12, req1 addr 4 → req0 not ready, req1 granted on port 0. Without the macro: req0 is granted on port 0 and req1 on port 1.
- Assert `reset` one cycle after granting req0 → `resp_valid` = 0 immediately, and stays 0 in the first cycle after reset release.
